// File: rtl/chaos_sbox_generator_if.sv
// ----------------------------------------------------------------------------
// chaos_sbox_generator_if
// Bundle between the chaotic S-box generator and its consumer.
//   start      : one-cycle request to build a new S-box (consumer -> generator)
//   seed       : initial chaotic state, sampled with start (consumer -> generator)
//   busy       : generator is building or streaming a table
//   sbox_valid : V_out carries an S-box entry this cycle
//   V_out      : S-box entry, streamed index 0 upward
//   sbox_done  : one-cycle pulse after the last entry
// Modports: master = generator (transmitting end), slave = consumer.
// ----------------------------------------------------------------------------
interface chaos_sbox_generator_if #(
   parameter int V_SIZE  = 8,
   parameter int X_WIDTH = 16
);
   logic               start;
   logic [X_WIDTH-1:0] seed;
   logic               busy;
   logic               sbox_valid;
   logic [V_SIZE-1:0]  V_out;
   logic               sbox_done;

   modport master (
      input  start, seed,
      output busy, sbox_valid, V_out, sbox_done
   );

   modport slave (
      output start, seed,
      input  busy, sbox_valid, V_out, sbox_done
   );
endinterface

// File: rtl/chaos_sbox_generator.sv
// ----------------------------------------------------------------------------
// chaos_sbox_generator
// Builds a key-dependent V_SIZE-bit S-box: seeds a fixed-point logistic map,
// shuffles the identity table with a chaos-driven Fisher-Yates pass and then
// streams the permutation, one entry per cycle, ending with a done pulse.
// Ports:
//   clk     : clock, all logic on the rising edge
//   reset   : synchronous, active-high reset (aborts any operation)
//   sbox_if : chaos_sbox_generator_if.master (start/seed in; busy, sbox_valid,
//             V_out, sbox_done out; all outputs registered)
// ----------------------------------------------------------------------------
module chaos_sbox_generator #(
   parameter int V_SIZE  = 8,
   parameter int X_WIDTH = 16,
   parameter int WARMUP  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   chaos_sbox_generator_if.master         sbox_if
);

   localparam int DEPTH = 1 << V_SIZE;
   localparam int WCW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   // Perturbation constant: low bits of the golden-ratio word.
   localparam logic [31:0]        GOLDEN = 32'h9E3779B9;
   localparam logic [X_WIDTH-1:0] K      = GOLDEN[X_WIDTH-1:0];

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_WARM = 3'd2,
      S_SHUF = 3'd3,
      S_OUT  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Fixed-point logistic map x*(1-x)*4 in Q0.X_WIDTH, with saturation and a
   // kick by K whenever the orbit collapses to zero or sits on a fixed point.
   function automatic logic [X_WIDTH-1:0] map_f(input logic [X_WIDTH-1:0] x);
      logic [2*X_WIDTH:0] xe;
      logic [2*X_WIDTH:0] ce;
      logic [2*X_WIDTH:0] p;
      logic [2*X_WIDTH:0] n_full;
      logic [X_WIDTH-1:0] n;
      xe     = (2*X_WIDTH+1)'(x);
      ce     = ((2*X_WIDTH+1)'(1'b1) << X_WIDTH) - xe;
      p      = xe * ce;
      n_full = p >> (X_WIDTH - 2);
      if (n_full > (2*X_WIDTH+1)'({X_WIDTH{1'b1}})) begin
         n = {X_WIDTH{1'b1}};
      end else begin
         n = X_WIDTH'(n_full);
      end
      if ((n == {X_WIDTH{1'b0}}) || (n == x)) begin
         map_f = n ^ K;
      end else begin
         map_f = n;
      end
   endfunction

   state_t             state_r, state_nxt_s;
   logic [X_WIDTH-1:0] x_r, x_nxt_s;
   logic [V_SIZE-1:0]  idx_r, idx_nxt_s;     // INIT/OUT index, shuffle i in SHUF
   logic [WCW-1:0]     warm_r, warm_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic               valid_r, valid_nxt_s;
   logic [V_SIZE-1:0]  vout_r, vout_nxt_s;
   logic               done_r, done_nxt_s;

   logic [V_SIZE-1:0]  table_r [DEPTH];

   logic [V_SIZE:0]    i_plus1_s;
   logic [2*V_SIZE-1:0] j_prod_s;
   logic [V_SIZE-1:0]  j_s;

   // Swap partner j = floor(top_bits(x) * (i+1) / 2^V_SIZE), always in 0..i.
   always_comb begin
      i_plus1_s = {1'b0, idx_r} + {{V_SIZE{1'b0}}, 1'b1};
      j_prod_s  = (2*V_SIZE)'(x_r[X_WIDTH-1 -: V_SIZE]) * (2*V_SIZE)'(i_plus1_s);
      j_s       = V_SIZE'(j_prod_s >> V_SIZE);
   end

   // Next-state and next-output logic for the control FSM.
   always_comb begin
      state_nxt_s = state_r;
      x_nxt_s     = x_r;
      idx_nxt_s   = idx_r;
      warm_nxt_s  = warm_r;
      busy_nxt_s  = busy_r;
      valid_nxt_s = 1'b0;
      vout_nxt_s  = vout_r;
      done_nxt_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            busy_nxt_s = 1'b0;
            if (sbox_if.start) begin
               if (sbox_if.seed == {X_WIDTH{1'b0}}) begin
                  x_nxt_s = K;
               end else begin
                  x_nxt_s = sbox_if.seed;
               end
               idx_nxt_s   = {V_SIZE{1'b0}};
               busy_nxt_s  = 1'b1;
               state_nxt_s = S_INIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_INIT: begin
            idx_nxt_s = idx_r + 1'b1;
            if (idx_r == {V_SIZE{1'b1}}) begin
               warm_nxt_s  = {WCW{1'b0}};
               state_nxt_s = S_WARM;
            end else begin
               state_nxt_s = S_INIT;
            end
         end
         S_WARM: begin
            x_nxt_s    = map_f(x_r);
            warm_nxt_s = warm_r + 1'b1;
            if (warm_r == WCW'(WARMUP - 1)) begin
               idx_nxt_s   = {V_SIZE{1'b1}};
               state_nxt_s = S_SHUF;
            end else begin
               state_nxt_s = S_WARM;
            end
         end
         S_SHUF: begin
            x_nxt_s   = map_f(x_r);
            idx_nxt_s = idx_r - 1'b1;
            if (idx_r == {{(V_SIZE-1){1'b0}}, 1'b1}) begin
               idx_nxt_s   = {V_SIZE{1'b0}};
               state_nxt_s = S_OUT;
            end else begin
               state_nxt_s = S_SHUF;
            end
         end
         S_OUT: begin
            valid_nxt_s = 1'b1;
            vout_nxt_s  = table_r[idx_r];
            idx_nxt_s   = idx_r + 1'b1;
            if (idx_r == {V_SIZE{1'b1}}) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_OUT;
            end
         end
         S_DONE: begin
            // busy stays high through this cycle; IDLE clears it.
            done_nxt_s  = 1'b1;
            state_nxt_s = S_IDLE;
         end
         default: begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         x_r     <= {X_WIDTH{1'b0}};
         idx_r   <= {V_SIZE{1'b0}};
         warm_r  <= {WCW{1'b0}};
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         vout_r  <= {V_SIZE{1'b0}};
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         x_r     <= x_nxt_s;
         idx_r   <= idx_nxt_s;
         warm_r  <= warm_nxt_s;
         busy_r  <= busy_nxt_s;
         valid_r <= valid_nxt_s;
         vout_r  <= vout_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Table storage: identity fill in INIT, one swap per cycle in SHUF.
   // Contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (state_r == S_INIT) begin
         table_r[idx_r] <= idx_r;
      end else if (state_r == S_SHUF) begin
         table_r[idx_r] <= table_r[j_s];
         table_r[j_s]   <= table_r[idx_r];
      end
   end

   assign sbox_if.busy       = busy_r;
   assign sbox_if.sbox_valid = valid_r;
   assign sbox_if.V_out      = vout_r;
   assign sbox_if.sbox_done  = done_r;

endmodule

// File: doc/chaos_sbox_generator.md
Name: chaos_sbox_generator

Overview:
- Produces the key-dependent 8-bit S-box that key_generator consumes.
- On start it seeds a fixed-point logistic map and performs a chaos-driven Fisher-Yates shuffle of the identity table 0..255.
- It then streams the 256-entry permutation on the sbox_valid/V_out interface and finishes with a one-cycle sbox_done pulse.
- It is the transmitting end of the S-box stream.

Parameters:
V_SIZE, 8, S-box entry width; the table depth is 2^V_SIZE (256).
X_WIDTH, 16, chaotic state width, unsigned Q0.X_WIDTH.
WARMUP, 16, number of map iterations discarded before the shuffle begins.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; accepted only in IDLE.
seed  input  X_WIDTH  initial chaotic state, sampled on the accepting edge.
busy  output  1  high from the cycle after start is accepted through the sbox_done cycle, inclusive.
sbox_valid  output  1  V_out carries an S-box entry this cycle.
V_out  output  V_SIZE  S-box entry, streamed from index 0 to index 255.
sbox_done  output  1  one-cycle pulse after the last entry.

Behaviour:
- Reset, applied in any state:
  - Next state is IDLE.
  - busy, sbox_valid and sbox_done go to 0; V_out goes to 0.
  - Table contents are don't-care; a reset mid-operation aborts with no further output.
- All outputs are registered.
- Map function f(x):
  - p = x*(2^X_WIDTH - x), computed in 2*X_WIDTH+1 bits.
  - n = p >> (X_WIDTH-2); if n >= 2^X_WIDTH, n saturates to 2^X_WIDTH-1.
  - If n == 0 or n == x, f(x) = n XOR K; otherwise f(x) = n.
  - K is the low X_WIDTH bits of 32'h9E3779B9 (16'h79B9 at the default width).
- Seed: seed == 0 is replaced by K when latched.
- IDLE: waits for start. On acceptance: x <= seed (or K), idx <= 0, busy <= 1, go to INIT. start in any other state is ignored.
- INIT, 256 cycles: table[idx] <= idx for idx 0..255, then go to WARM.
- WARM, WARMUP cycles: x <= f(x) each cycle. Then i <= 255, go to SHUF.
- SHUF, one cycle per i, for i = 255 down to 1:
  - j = (x[X_WIDTH-1 -: 8] * (i+1)) >> 8, which always lies in 0..i.
  - Swap table[i] and table[j]; j == i leaves the table unchanged.
  - x <= f(x).
  - After i == 1, go to OUT with idx <= 0. The shuffle takes 255 cycles.
- OUT, 256 cycles:
  - sbox_valid = 1 and V_out = table[idx], idx 0..255, with no gaps.
  - Then go to DONE.
- DONE, 1 cycle:
  - sbox_valid = 0, sbox_done = 1; V_out holds its last value.
  - Next cycle: busy = 0, sbox_done = 0, return to IDLE.
- No back-pressure: the consumer must accept one entry per cycle.
- Latency with defaults:
  - Let edge E be the one that samples start.
  - First sbox_valid is registered at edge E+528 (256+16+255+1).
  - Last valid is at E+783; sbox_done is at E+784.
- Output guarantee: V_out over the 256 valid cycles is a permutation of 0..255.
- Determinism: identical seeds give identical streams.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset, then start with seed=16'h1234 → sbox_valid rises exactly 528 cycles after the start edge, stays high for 256 contiguous cycles, and sbox_done pulses once on the following cycle with sbox_valid=0. The 256 values collected are all distinct and cover 0..255.
- Run seed=16'h1234 twice back-to-back → the two streams are bit-identical. Running seed=16'h1235 → the stream differs from the first in at least one position.
- seed=16'h0000 versus seed=16'h79B9 → identical streams. seed=16'hC000, a logistic fixed point → the XOR-K rule fires and the output is still a valid permutation.
- Pulse start every cycle while busy=1 → no restart; exactly 256 valid cycles and 1 done pulse per accepted start.
- Assert reset for one cycle at the 100th valid cycle → sbox_valid=0, sbox_done never pulses, busy=0 next cycle. A subsequent start with seed=16'h1234 reproduces the full reference stream.
- Connect to key_generator (V_SIZE=8, KEY_SIZE=128, ROUND=5, initial_key=128'h0123456789ABCDEF_FEDCBA9876543210) → key_generator receives 256 entries and one sbox_done, and asserts its valid/done_key.
